sync_fifo_param: RTL
====================

Name: sync_fifo_param

Overview:
- Parametrised synchronous FIFO for single-clock datapaths; successor to the team's fixed 8x8 FIFO.
- Adds configurable width/depth, occupancy count, programmable almost-full/almost-empty thresholds, per-cycle error pulses with sticky error status, and an optional first-word-fall-through (FWFT) read mode.
- Sits between producer and consumer stages that need back-pressure and early-warning watermarks.

Parameters:
- DATA_W, 8, data word width in bits (>=1).
- DEPTH, 16, number of entries; power of two, >=4.
- AFULL_TH, 12, almost_full asserts when count >= AFULL_TH (1..DEPTH-1).
- AEMPTY_TH, 4, almost_empty asserts when count <= AEMPTY_TH (1..DEPTH-1).
- AW (local), clog2(DEPTH); pointers are AW+1 bits, with the MSB used as the wrap bit.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- wr_en  in  1  write request.
- d_in  in  DATA_W  write data.
- rd_en  in  1  read request.
- d_out  out  DATA_W  read data (registered).
- full  out  1  count == DEPTH.
- empty  out  1  count == 0 (in FWFT mode: no valid word on d_out).
- almost_full  out  1  count >= AFULL_TH.
- almost_empty  out  1  count <= AEMPTY_TH.
- count  out  AW+1  occupancy, 0..DEPTH.
- overflow  out  1  one-cycle pulse: wr_en while full.
- underflow  out  1  one-cycle pulse: rd_en while empty.
- err_clr  in  1  clears the sticky error bits.
- err_sticky  out  2  {overflow seen, underflow seen}; held until err_clr.

Behaviour:
- Reset (asynchronous, effective immediately):
  - Pointers, count, d_out and all error outputs = 0.
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0.
  - Mid-operation reset discards contents; memory array is not cleared.
- Write accepted iff wr_en && !full. The data goes to mem[wr_ptr[AW-1:0]] and wr_ptr increments.
- Read accepted iff rd_en && !empty. d_out <= mem[rd_ptr[AW-1:0]] on that edge (1-cycle read latency) and rd_ptr increments. d_out holds its value when no read is accepted.
- Simultaneous accepted read and write: count is unchanged and both pointers advance.
  - When full, a write with a read is rejected (no pass-through); the read alone proceeds.
  - When empty, a read with a write is rejected; the write alone proceeds.
- All flags and count are registered from next-state count, so they are valid in the cycle after the causing edge and never lag by more than one edge.
- Pointer wrap: the low AW bits index memory, and the MSB toggles on each wrap.
  - full when the MSBs differ and the low bits are equal.
  - empty when the pointers are equal.
  - count = wr_ptr - rd_ptr (mod 2^(AW+1)) and must match these flags.
- Errors:
  - overflow <= wr_en && full; underflow <= rd_en && empty. Each is a one-cycle pulse per offending cycle, and pointers and memory are unchanged by the rejected request.
  - err_sticky bits are set by the pulses and cleared by err_clr.
  - If err_clr and a new error occur in the same cycle, set wins.

Optional Feature:
- Macro SYNC_FIFO_FWFT_EN.
- Defined (FWFT mode):
  - The head word is prefetched into the d_out register; d_out is valid whenever empty = 0.
  - rd_en acts as an acknowledge that pops the head and loads the next word on the same edge.
  - After a write into an empty FIFO, d_out is valid and empty = 0 after the following edge, i.e. 2 edges after the write.
  - count includes the prefetched word.
- Undefined: standard mode as described above; no prefetch logic is synthesised.

Test Plan:
- Reset then idle -> empty=1, almost_empty=1, full=0, count=0, d_out=0, err_sticky=0.
- Write 0x01..0x10 (16 words, DEPTH=16) -> count steps 1..16; almost_full rises when count=12; full=1 at count 16. Read all 16 -> d_out sequence 0x01..0x10, each one cycle after rd_en; empty=1 at end.
- With full=1, wr_en with d_in=0xAA -> overflow pulses for 1 cycle, err_sticky[1]=1, count stays 16, and 0xAA is never read. err_clr -> err_sticky=0.
- With empty, rd_en -> underflow pulses and err_sticky[0]=1; d_out is unchanged.
- At count=5, hold wr_en=rd_en=1 for 40 cycles with an incrementing pattern -> count stays 5 and data order is preserved across pointer wrap.
- Assert rst_n=0 asynchronously at count=9 -> flags return to reset values before the next clock edge; the next word written is the first word read.
- (FWFT build) Write 0x5A into an empty FIFO -> d_out=0x5A and empty=0 two edges after the write, with no rd_en. rd_en -> empty=1 on the next edge.

Source files
------------

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with occupancy count, watermarks and error status.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads (head word prefetched into d_out).
module sync_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          d_in,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          d_out,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       err_clr,
  output logic [1:0]                 err_sticky
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ZERO_C    = {(AW+1){1'b0}};
  localparam logic [AW:0] ONE_C     = (AW+1)'(1);
  localparam logic [AW:0] DEPTH_C   = (AW+1)'(DEPTH);
  localparam logic [AW:0] AFULL_C   = (AW+1)'(AFULL_TH);
  localparam logic [AW:0] AEMPTY_C  = (AW+1)'(AEMPTY_TH);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [AW:0]       wr_ptr_r;
  logic [AW:0]       rd_ptr_r;
  logic [AW:0]       count_nxt_s;
  logic              wr_acc_s;
  logic              rd_acc_s;
  logic              mem_rd_s;
  logic              empty_nxt_s;

  // Full rejects writes and empty rejects reads, so there is never pass-through.
  assign wr_acc_s = wr_en & ~full;
  assign rd_acc_s = rd_en & ~empty;

`ifdef SYNC_FIFO_FWFT_EN
  logic        ov_r;
  logic        ov_nxt_s;
  logic [AW:0] mem_cnt_s;

  // Refill the output register whenever it holds nothing or is being popped.
  assign mem_cnt_s   = wr_ptr_r - rd_ptr_r;
  assign mem_rd_s    = (mem_cnt_s != ZERO_C) & (~ov_r | rd_acc_s);
  assign ov_nxt_s    = mem_rd_s | (ov_r & ~rd_acc_s);
  assign empty_nxt_s = ~ov_nxt_s;

  // Valid flag for the prefetched head word in d_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov_r <= 1'b0;
    end else begin
      ov_r <= ov_nxt_s;
    end
  end
`else
  assign mem_rd_s    = rd_acc_s;
  assign empty_nxt_s = (count_nxt_s == ZERO_C);
`endif

  // Next occupancy: a simultaneous accepted read and write leaves it unchanged.
  always_comb begin
    count_nxt_s = count;
    if (wr_acc_s && !rd_acc_s) begin
      count_nxt_s = count + ONE_C;
    end else if (!wr_acc_s && rd_acc_s) begin
      count_nxt_s = count - ONE_C;
    end else begin
      count_nxt_s = count;
    end
  end

  // Storage array; deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= d_in;
    end
  end

  // Pointers, read data, flags and error status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r     <= ZERO_C;
      rd_ptr_r     <= ZERO_C;
      d_out        <= {DATA_W{1'b0}};
      count        <= ZERO_C;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      err_sticky   <= 2'b00;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + ONE_C;
      end
      if (mem_rd_s) begin
        d_out    <= mem_r[rd_ptr_r[AW-1:0]];
        rd_ptr_r <= rd_ptr_r + ONE_C;
      end
      count        <= count_nxt_s;
      full         <= (count_nxt_s == DEPTH_C);
      empty        <= empty_nxt_s;
      almost_full  <= (count_nxt_s >= AFULL_C);
      almost_empty <= (count_nxt_s <= AEMPTY_C);
      overflow     <= wr_en & full;
      underflow    <= rd_en & empty;
      // A new error in the same cycle as err_clr keeps its bit set.
      err_sticky   <= (err_clr ? 2'b00 : err_sticky) | {wr_en & full, rd_en & empty};
    end
  end

endmodule
